axil_reg_bridge: RTL
====================

// Module: axil_reg_bridge
// PURPOSE
//  AXI4-Lite subordinate front end that converts bus transactions into the
//  register-file access ports (write_en/write_addr/write_data, read_addr/read_data).
//  Sits between the SoC interconnect and the GPIO/PWM register file.
//  Runs independent write (AW/W/B) and read (AR/R) engines with single-outstanding
//  transactions, and returns OKAY/SLVERR responses.
// PARAMETERS
//  ADDR_WIDTH      4   register-file address width (byte address, low bits of AXI addr)
//  DATA_WIDTH      32  data width; fixed 32 for AXI4-Lite, STRB_W = DATA_WIDTH/8
//  AXI_ADDR_WIDTH  32  width of s_awaddr/s_araddr
// PORTS
//  clk            in   1               clock; all logic on rising edge
//  rst_n          in   1               asynchronous active-low reset
//  s_awaddr       in   AXI_ADDR_WIDTH  write address
//  s_awvalid      in   1 / s_awready out 1   AW handshake
//  s_wdata        in   DATA_WIDTH      write data
//  s_wstrb        in   STRB_W          write byte strobes
//  s_wvalid       in   1 / s_wready  out 1   W handshake
//  s_bresp        out  2               write response (00 OKAY, 10 SLVERR)
//  s_bvalid       out  1 / s_bready  in  1   B handshake
//  s_araddr       in   AXI_ADDR_WIDTH  read address
//  s_arvalid      in   1 / s_arready out 1   AR handshake
//  s_rdata        out  DATA_WIDTH      read data
//  s_rresp        out  2               read response
//  s_rvalid       out  1 / s_rready  in  1   R handshake
//  write_en       out  1               1-cycle register write strobe
//  write_addr     out  ADDR_WIDTH      = captured awaddr[ADDR_WIDTH-1:0]
//  write_data     out  DATA_WIDTH      = captured wdata
//  read_addr      out  ADDR_WIDTH      = captured araddr[ADDR_WIDTH-1:0]
//  read_data      in   DATA_WIDTH      combinational register read data
// BEHAVIOUR
//  Reset (rst_n low, async): all outputs 0; write FSM=W_IDLE, read FSM=R_IDLE.
//   Readies held 0 until first clk edge after release (rdy_en flop), then per state.
//  Write FSM: W_IDLE -> W_EXEC -> W_RESP -> W_IDLE.
//   s_awready=1 while W_IDLE and AW not yet held; s_wready=1 while W_IDLE and W not held.
//   AW and W accepted in either order or in the same cycle; each is held in its own flop.
//   Leave W_IDLE at the edge where both are held. W_EXEC lasts 1 cycle.
//   write_en=1 in W_EXEC only when the access is legal: awaddr[1:0]==0 and wstrb all-ones.
//   Illegal access: no write_en, bresp=SLVERR.
//   W_RESP: bvalid=1, bresp stable until s_bready; the handshake edge returns to W_IDLE.
//   Latency: both held at edge N -> write_en high cycle N..N+1 -> bvalid from edge N+1.
//  Read FSM: R_IDLE -> R_FETCH -> R_RESP -> R_IDLE.
//   s_arready=1 only in R_IDLE. read_addr is registered at the AR handshake.
//   R_FETCH lasts 1 cycle and samples read_data into s_rdata.
//   Misaligned araddr: rdata=0, rresp=SLVERR. Otherwise rresp=OKAY.
//   Unmapped addresses return regfile data (32'hDEAD_BEEF) with OKAY.
//   R_RESP: rvalid=1; rdata/rresp stable until s_rready.
//  Read and write engines are fully independent; both may be active at once.
//   A read sampled in the same cycle as write_en to the same address returns the old value.
//  No new AW/W/AR is accepted until the prior response completes (1 outstanding per dir).
//  Stalled bready/rready: the FSM waits indefinitely with outputs frozen.
//  Reset mid-transaction: the transaction is dropped; no write_en after reset release.
//  Address bits above ADDR_WIDTH are ignored (aliasing is permitted).
// TESTING
//  AW+W same cycle, addr 0x0, data 0xA5, strb F -> write_en 1 cycle, write_data 0xA5,
//   bvalid 2 cycles after accept, bresp 00.
//  W 3 cycles before AW, addr 0x8 -> single write_en after AW; awready low after
//   bready until back in W_IDLE.
//  Write with strb 4'h3 or addr 0x2 -> no write_en, bresp 10; a later read of that
//   address returns the unchanged value.
//  Read addr 0x4 with read_data = 0x0000_005A -> rvalid 2 cycles after AR, rdata
//   0x5A, rresp 00. Hold rready=0 for 5 cycles -> rdata stable.
//  Concurrent write 0xC=0x1234 and read 0xC issued together -> read returns the old
//   value; next read returns 0x1234.
//  Assert rst_n low during W_EXEC/R_RESP -> all outputs 0 immediately; no write_en
//   afterwards; readies 0 in the first cycle after release.

Source files
------------

// File: rtl/axil_reg_bridge_if.sv
// AXI4-Lite subordinate-side bus bundle used between the interconnect and the
// register bridge; "slave" is the bridge view, "master" the interconnect view.
interface axil_reg_bridge_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0] s_awaddr;
  logic                      s_awvalid;
  logic                      s_awready;
  logic [DATA_WIDTH-1:0]     s_wdata;
  logic [STRB_W-1:0]         s_wstrb;
  logic                      s_wvalid;
  logic                      s_wready;
  logic [1:0]                s_bresp;
  logic                      s_bvalid;
  logic                      s_bready;
  logic [AXI_ADDR_WIDTH-1:0] s_araddr;
  logic                      s_arvalid;
  logic                      s_arready;
  logic [DATA_WIDTH-1:0]     s_rdata;
  logic [1:0]                s_rresp;
  logic                      s_rvalid;
  logic                      s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, output s_awready,
    input  s_wdata, s_wstrb, s_wvalid, output s_wready,
    output s_bresp, s_bvalid, input s_bready,
    input  s_araddr, s_arvalid, output s_arready,
    output s_rdata, s_rresp, s_rvalid, input s_rready
  );

  modport master (
    output s_awaddr, s_awvalid, input s_awready,
    output s_wdata, s_wstrb, s_wvalid, input s_wready,
    input  s_bresp, s_bvalid, output s_bready,
    output s_araddr, s_arvalid, input s_arready,
    input  s_rdata, s_rresp, s_rvalid, output s_rready
  );
endinterface

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite subordinate that turns bus transactions into a simple register-file
// port; independent single-outstanding write (AW/W/B) and read (AR/R) engines.
module axil_reg_bridge #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axil_reg_bridge_if.slave      axi,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} rstate_t;

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;

  logic                  rdy_en;
  logic                  aw_held, w_held;
  logic [STRB_W-1:0]     wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  aw_take, w_take, ar_take;
  logic                  w_legal, r_misaligned;
  logic                  bvalid, rvalid;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{axi.s_awaddr[AXI_ADDR_WIDTH-1:ADDR_WIDTH],
                              axi.s_araddr[AXI_ADDR_WIDTH-1:ADDR_WIDTH]};

  // Readies stay low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  assign axi.s_awready = (wstate == W_IDLE) && rdy_en && !aw_held;
  assign axi.s_wready  = (wstate == W_IDLE) && rdy_en && !w_held;
  assign axi.s_arready = (rstate == R_IDLE) && rdy_en;

  assign aw_take = axi.s_awready && axi.s_awvalid;
  assign w_take  = axi.s_wready  && axi.s_wvalid;
  assign ar_take = axi.s_arready && axi.s_arvalid;

  assign w_legal      = (write_addr[1:0] == 2'b00) && (&wstrb_q);
  assign r_misaligned = (read_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= wstate_nxt;
      rstate <= rstate_nxt;
    end
  end

  always_comb begin
    wstate_nxt = wstate;
    write_en   = 1'b0;
    bvalid     = 1'b0;
    case (wstate)
      W_IDLE: if ((aw_held || aw_take) && (w_held || w_take)) wstate_nxt = W_EXEC;
      W_EXEC: begin
        write_en   = w_legal;
        wstate_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (axi.s_bready) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_nxt = rstate;
    rvalid     = 1'b0;
    case (rstate)
      R_IDLE:  if (ar_take) rstate_nxt = R_FETCH;
      R_FETCH: rstate_nxt = R_RESP;
      R_RESP: begin
        rvalid = 1'b1;
        if (axi.s_rready) rstate_nxt = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  assign axi.s_bvalid = bvalid;
  assign axi.s_bresp  = (bvalid && !w_legal) ? RESP_SLVERR : RESP_OKAY;
  assign axi.s_rvalid = rvalid;
  assign axi.s_rdata  = rdata_q;
  assign axi.s_rresp  = rresp_q;

  // AW and W are captured independently; both hold flags clear as the write executes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      wstrb_q    <= '0;
    end else begin
      if (aw_take) begin
        aw_held    <= 1'b1;
        write_addr <= axi.s_awaddr[ADDR_WIDTH-1:0];
      end
      if (w_take) begin
        w_held     <= 1'b1;
        write_data <= axi.s_wdata;
        wstrb_q    <= axi.s_wstrb;
      end
      if (wstate == W_EXEC) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // Read data is sampled at the end of R_FETCH, before any same-cycle register write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_addr <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      if (ar_take) read_addr <= axi.s_araddr[ADDR_WIDTH-1:0];
      if (rstate == R_FETCH) begin
        rdata_q <= r_misaligned ? '0 : read_data;
        rresp_q <= r_misaligned ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end
endmodule
